// File: rtl/apb_uart_tx_pkg.sv
// apb_uart_tx_pkg
//   Shared definitions for the APB UART transmitter (and its RX counterpart):
//   FSM state encoding, line levels of the start/stop bits and the default
//   frame parameters.
//   No ports.
package apb_uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam logic START_BIT     = 1'b0;
    localparam logic STOP_BIT      = 1'b1;
    localparam int   DEF_CLK_DIV   = 16;
    localparam int   DEF_DATA_BITS = 8;

endpackage

// File: rtl/apb_uart_baud.sv
// apb_uart_baud
//   Baud counter shared by the UART TX and RX datapaths. Counts 0..CLK_DIV-1
//   while run is high and flags the last clock of each serial bit.
//   Ports:
//     clk      in   system clock, rising edge
//     rst      in   asynchronous active-high reset
//     clear    in   synchronous restart of the count at 0 (has priority over run)
//     run      in   count enable; the count is held at 0 while low
//     bit_tick out  high on the last clock of a bit period (count == CLK_DIV-1)
//     count    out  current count value
module apb_uart_baud
    import apb_uart_tx_pkg::*;
#(
    parameter  int CLK_DIV = DEF_CLK_DIV,
    localparam int CW      = $clog2(CLK_DIV)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          run,
    output logic          bit_tick,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_r;

    // Bit-period counter: wraps at each bit boundary, parked at 0 when not running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (clear) begin
            cnt_r <= {CW{1'b0}};
        end else if (run) begin
            if (cnt_r == LAST) begin
                cnt_r <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end else begin
            cnt_r <= {CW{1'b0}};
        end
    end

    assign bit_tick = run & (cnt_r == LAST);
    assign count    = cnt_r;

endmodule

// File: rtl/apb_uart_tx.sv
// apb_uart_tx
//   UART transmitter. Each accepted APB write is sent as one frame:
//   start bit (0), DATA_BITS data bits LSB first, one stop bit (1).
//   The sampling edge of an accepted write is the first edge of the frame,
//   so a frame occupies exactly (DATA_BITS+2)*CLK_DIV clocks after it.
//   Ports:
//     clk      in   system clock, rising edge
//     rst      in   asynchronous active-high reset
//     sel      in   APB peripheral select
//     tx_en    in   transmitter enable
//     wr       in   write strobe (load request)
//     wdata    in   word to send; only wdata[DATA_BITS-1:0] is used
//     tx_out   out  registered serial line, idles at 1
//     tx_busy  out  high while a frame is in flight
//     tx_done  out  one-clock pulse on the final clock of the stop bit
module apb_uart_tx
    import apb_uart_tx_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int DATA_BITS = DEF_DATA_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        tx_en,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic        tx_out,
    output logic        tx_busy,
    output logic        tx_done
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(CLK_DIV - 2);

    uart_state_e          state_r, state_s;
    logic [DATA_BITS-1:0] shift_r, shift_s;
    logic [BW-1:0]        bit_cnt_r, bit_cnt_s;
    logic                 tx_out_s, tx_busy_s, tx_done_s;
    logic                 accept_s;
    logic                 bit_tick_s;
    logic [CW-1:0]        baud_cnt_s;
    logic                 unused_s;

    // Upper write-data bits are intentionally never transmitted.
    assign unused_s = ^wdata[31:DATA_BITS];

    apb_uart_baud #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept_s),
        .run      (state_r != ST_IDLE),
        .bit_tick (bit_tick_s),
        .count    (baud_cnt_s)
    );

    // Next-state, shift/bit-count updates and next values of the output registers.
    always_comb begin
        accept_s  = sel & tx_en & wr & (state_r == ST_IDLE);
        state_s   = state_r;
        shift_s   = shift_r;
        bit_cnt_s = bit_cnt_r;
        tx_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_START;
                    shift_s = wdata[DATA_BITS-1:0];
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_tick_s) begin
                    state_s   = ST_DATA;
                    bit_cnt_s = {BW{1'b0}};
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_tick_s) begin
                    shift_s = {1'b0, shift_r[DATA_BITS-1:1]};
                    if (bit_cnt_r == LAST_BIT) begin
                        state_s   = ST_STOP;
                        bit_cnt_s = {BW{1'b0}};
                    end else begin
                        bit_cnt_s = bit_cnt_r + BW'(1);
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (bit_tick_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_STOP;
                end
                // Registered pulse: raise it one clock early so it lands on the last stop clock.
                tx_done_s = (baud_cnt_s == PRE_LAST);
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Line level follows the state being entered, giving a registered tx_out with no extra lag.
        case (state_s)
            ST_START: tx_out_s = START_BIT;
            ST_DATA:  tx_out_s = shift_s[0];
            ST_STOP:  tx_out_s = STOP_BIT;
            default:  tx_out_s = STOP_BIT;
        endcase
        tx_busy_s = (state_s != ST_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            shift_r   <= {DATA_BITS{1'b0}};
            bit_cnt_r <= {BW{1'b0}};
            tx_out    <= STOP_BIT;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state_r   <= state_s;
            shift_r   <= shift_s;
            bit_cnt_r <= bit_cnt_s;
            tx_out    <= tx_out_s;
            tx_busy   <= tx_busy_s;
            tx_done   <= tx_done_s;
        end
    end

endmodule

// File: tb/tb_apb_uart_tx.sv
// tb_apb_uart_tx
//   Three transmitters with different frame shapes share one stimulus stream.
//   Each output is compared every clock against a frame-timing model, and a
//   bench-side receiver decodes each serial line independently of that model.
module tb_apb_uart_tx;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        sel   = 1'b0;
    logic        tx_en = 1'b0;
    logic        wr    = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic [2:0]  tx_o, busy_o, done_o;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Frame model: accept edge and latched word per instance.
    int          acc_at [3] = '{-1000, -1000, -1000};
    bit          act    [3] = '{1'b0, 1'b0, 1'b0};
    logic [31:0] dat    [3];

    // Bench receiver state per instance.
    bit          rx_act  [3] = '{1'b0, 1'b0, 1'b0};
    int          rx_cnt  [3];
    logic [31:0] rx_word [3];
    logic        prev_tx [3] = '{1'b1, 1'b1, 1'b1};

    always #5 clk = ~clk;

    apb_uart_tx #(.CLK_DIV(4), .DATA_BITS(8)) dut0 (
        .clk(clk), .rst(rst), .sel(sel), .tx_en(tx_en), .wr(wr), .wdata(wdata),
        .tx_out(tx_o[0]), .tx_busy(busy_o[0]), .tx_done(done_o[0]));
    apb_uart_tx #(.CLK_DIV(2), .DATA_BITS(5)) dut1 (
        .clk(clk), .rst(rst), .sel(sel), .tx_en(tx_en), .wr(wr), .wdata(wdata),
        .tx_out(tx_o[1]), .tx_busy(busy_o[1]), .tx_done(done_o[1]));
    apb_uart_tx #(.CLK_DIV(5), .DATA_BITS(10)) dut2 (
        .clk(clk), .rst(rst), .sel(sel), .tx_en(tx_en), .wr(wr), .wdata(wdata),
        .tx_out(tx_o[2]), .tx_busy(busy_o[2]), .tx_done(done_o[2]));

    function automatic int cdiv(int k);
        case (k)
            0:       return 4;
            1:       return 2;
            default: return 5;
        endcase
    endfunction

    function automatic int dbits(int k);
        case (k)
            0:       return 8;
            1:       return 5;
            default: return 10;
        endcase
    endfunction

    function automatic int flen(int k);
        return (dbits(k) + 2) * cdiv(k);
    endfunction

    function automatic logic [31:0] mask(int k);
        return (32'h1 << dbits(k)) - 32'h1;
    endfunction

    // Busy in the clock period that follows edge 'at'.
    function automatic bit mbusy(int k, int at);
        int t;
        t = at - acc_at[k];
        return act[k] && (t >= 0) && (t < flen(k));
    endfunction

    function automatic logic exp_tx(int k);
        int t;
        int idx;
        if (!mbusy(k, cyc)) return 1'b1;
        t   = cyc - acc_at[k];
        idx = t / cdiv(k);
        if (idx == 0) return 1'b0;
        if (idx <= dbits(k)) return dat[k][idx-1];
        return 1'b1;
    endfunction

    function automatic logic exp_done(int k);
        return mbusy(k, cyc) && ((cyc - acc_at[k]) == flen(k) - 1);
    endfunction

    task automatic chk(input string tag, input int k, input logic got, input logic want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s dut%0d cyc %0d: observed %b expected %b", tag, k, cyc, got, want);
        end
    endtask

    task automatic chk32(input string tag, input int k, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s dut%0d cyc %0d: observed %h expected %h", tag, k, cyc, got, want);
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                act[k] = 1'b0;
            end else if (sel && tx_en && wr && !mbusy(k, cyc - 1)) begin
                act[k]    = 1'b1;
                acc_at[k] = cyc;
                dat[k]    = wdata;
            end
        end
    endtask

    // Mid-bit sampling receiver, started by a 1->0 transition on the line.
    task automatic rx_step(input int k);
        int h;
        int i;
        h = cdiv(k) / 2;
        if (rst) begin
            rx_act[k] = 1'b0;
        end else if (!rx_act[k]) begin
            if (prev_tx[k] === 1'b1 && tx_o[k] === 1'b0) begin
                rx_act[k]  = 1'b1;
                rx_cnt[k]  = 0;
                rx_word[k] = 32'h0;
            end
        end else begin
            rx_cnt[k]++;
            if (rx_cnt[k] >= h && ((rx_cnt[k] - h) % cdiv(k)) == 0) begin
                i = (rx_cnt[k] - h) / cdiv(k);
                if (i >= 1 && i <= dbits(k)) begin
                    rx_word[k][i-1] = tx_o[k];
                end else if (i == dbits(k) + 1) begin
                    chk("rx_stop", k, tx_o[k], 1'b1);
                    chk32("rx_data", k, rx_word[k], dat[k] & mask(k));
                    rx_act[k] = 1'b0;
                end
            end
        end
        prev_tx[k] = rst ? 1'b1 : tx_o[k];
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk("tx_out", k, tx_o[k], exp_tx(k));
            chk("tx_busy", k, busy_o[k], mbusy(k, cyc));
            chk("tx_done", k, done_o[k], exp_done(k));
            rx_step(k);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input logic [31:0] d);
        wdata = d;
        wr    = 1'b1;
        step();
        wr    = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        for (int i = 0; i < 200 && mbusy(k, cyc); i++) step();
    endtask

    task automatic wait_all_idle();
        for (int i = 0; i < 200 && (mbusy(0, cyc) || mbusy(1, cyc) || mbusy(2, cyc)); i++) step();
    endtask

    // Asynchronous reset between clock edges: outputs must clear without a clock.
    task automatic rst_mid();
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("async_tx_out", k, tx_o[k], 1'b1);
            chk("async_tx_busy", k, busy_o[k], 1'b0);
            chk("async_tx_done", k, done_o[k], 1'b0);
            act[k]    = 1'b0;
            rx_act[k] = 1'b0;
        end
        run(2);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        run(3);
        rst = 1'b0;
        step();

        // Single 0xA5 frame: 0,1,0,1,0,0,1,0,1,1 on dut0, tx_done on cycle 40
        sel   = 1'b1;
        tx_en = 1'b1;
        load(32'h0000_00A5);
        run(45);

        // Write while busy is dropped
        load(32'h0000_00A5);
        run(6);
        load(32'h0000_003C);
        wait_all_idle();
        run(2);

        // Gated writes while idle
        sel = 1'b0;
        load(32'h0000_0055);
        run(5);
        sel   = 1'b1;
        tx_en = 1'b0;
        load(32'h0000_0055);
        run(5);
        tx_en = 1'b1;

        // Back-to-back on dut0: load in the first idle period
        load(32'h0000_00FF);
        wait_idle(0);
        load(32'h0000_0001);
        wait_all_idle();
        run(2);

        // tx_en dropped at data bit 3 of dut0; later write ignored until re-enabled
        load(32'h0000_00C3);
        run(15);
        tx_en = 1'b0;
        wait_all_idle();
        load(32'h0000_0066);
        run(3);
        tx_en = 1'b1;
        load(32'h0000_0099);
        wait_all_idle();

        // Reset mid-frame, then a normal frame
        load(32'h0000_005A);
        run(10);
        rst_mid();
        load(32'h0000_003C);
        wait_all_idle();

        // All-ones word: only DATA_BITS ones may appear
        load(32'hFFFF_FFFF);
        wait_all_idle();
        run(2);

        // Randomized traffic
        for (int n = 0; n < 900; n++) begin
            sel   = ($urandom_range(0, 9) != 0);
            tx_en = ($urandom_range(0, 9) != 0);
            wr    = ($urandom_range(0, 4) == 0);
            wdata = $urandom();
            step();
            if ($urandom_range(0, 299) == 0) rst_mid();
        end
        wr    = 1'b0;
        sel   = 1'b1;
        tx_en = 1'b1;
        wait_all_idle();
        run(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
